seg7_readback: RTL and testbench

Receiver-side decoder for the multiplexed 7-segment display bus. It samples segment patterns and the active-low digit-select lines, and applies a per-digit stability filter. Each stable pattern is decoded back to a 4-bit digit code, and a full multi-digit frame is assembled and published with a one-cycle valid strobe. Used on-chip to read the score and step counters back from the display path for self-check and for the verification bench.

---
 rtl/seg7_readback.sv | 187 ++++++++++++++++++
 tb/tb_seg7_readback.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_readback.sv
// seg7_readback: decodes the multiplexed 7-segment bus back into digit codes and publishes whole frames.
// Optional frame watchdog is compiled in when SEG7_RB_TIMEOUT_EN is defined.
module seg7_readback #(
   parameter int DIGITS      = 4,
   parameter int STABLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 65536
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          seg_i,
   input  logic [DIGITS-1:0]   sel_n_i,
   output logic [4*DIGITS-1:0] digit_o,
   output logic                frame_valid_o,
   output logic                bad_seg_o,
   output logic                stale_o
);
   localparam int RUN_W = $clog2(STABLE_CYC + 1);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(32'd1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYC);
   localparam logic [RUN_W-1:0] RUN_ARM = RUN_W'(STABLE_CYC - 1);

   // Returns {illegal, code}; dash decodes to 4'hA and is legal.
   function automatic logic [4:0] seg_decode(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         7'b1000000: res = {1'b0, 4'h0};
         7'b1111001: res = {1'b0, 4'h1};
         7'b0100100: res = {1'b0, 4'h2};
         7'b0110000: res = {1'b0, 4'h3};
         7'b0011001: res = {1'b0, 4'h4};
         7'b0010010: res = {1'b0, 4'h5};
         7'b0000010: res = {1'b0, 4'h6};
         7'b1111000: res = {1'b0, 4'h7};
         7'b0000000: res = {1'b0, 4'h8};
         7'b0010000: res = {1'b0, 4'h9};
         7'b0111111: res = {1'b0, 4'hA};
         default:    res = {1'b1, 4'hF};
      endcase
      return res;
   endfunction

   function automatic logic one_low(input logic [DIGITS-1:0] sel_n);
      int unsigned n;
      n = 32'd0;
      for (int i = 0; i < DIGITS; i++) begin
         n = n + {31'd0, ~sel_n[i]};
      end
      return (n == 32'd1);
   endfunction

   logic [6:0]          r_seg;
   logic [DIGITS-1:0]   r_sel;
   logic [RUN_W-1:0]    r_run;
   logic [DIGITS-1:0]   r_seen;
   logic                r_frame_bad;
   logic [4*DIGITS-1:0] r_shadow;
   logic [4*DIGITS-1:0] r_pub;
   logic                r_pub_bad;
   logic                r_pub_stb;

   logic                w_same;
   logic                w_capture;
   logic [4:0]          w_dec;
   logic [DIGITS-1:0]   w_sel_hot;
   logic [DIGITS-1:0]   w_seen_nxt;
   logic [4*DIGITS-1:0] w_shadow_nxt;
   logic                w_done;
   logic                w_timeout;

   // Capture qualification, decode and next frame contents.
   always_comb begin
      w_same       = ({seg_i, sel_n_i} == {r_seg, r_sel});
      w_sel_hot    = ~sel_n_i;
      w_dec        = seg_decode(seg_i);
      w_capture    = w_same && (r_run == RUN_ARM) && one_low(sel_n_i);
      w_seen_nxt   = r_seen;
      w_shadow_nxt = r_shadow;
      if (w_capture) begin
         w_seen_nxt = r_seen | w_sel_hot;
         for (int i = 0; i < DIGITS; i++) begin
            if (w_sel_hot[i]) begin
               w_shadow_nxt[4*i +: 4] = w_dec[3:0];
            end else begin
               w_shadow_nxt[4*i +: 4] = r_shadow[4*i +: 4];
            end
         end
      end else begin
         w_seen_nxt   = r_seen;
         w_shadow_nxt = r_shadow;
      end
      w_done = w_capture && (&w_seen_nxt);
   end

   // Stability filter, frame assembly and publish staging.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_seg       <= 7'h7F;
         r_sel       <= '1;
         r_run       <= '0;
         r_seen      <= '0;
         r_frame_bad <= 1'b0;
         r_shadow    <= '0;
         r_pub       <= '0;
         r_pub_bad   <= 1'b0;
         r_pub_stb   <= 1'b0;
      end else begin
         r_seg    <= seg_i;
         r_sel    <= sel_n_i;
         r_shadow <= w_shadow_nxt;
         if (!w_same) begin
            r_run <= RUN_ONE;
         end else if (r_run != RUN_MAX) begin
            r_run <= r_run + RUN_ONE;
         end
         // A watchdog expiry drops the partial frame even if a digit lands on the same edge.
         if (w_done || w_timeout) begin
            r_seen      <= '0;
            r_frame_bad <= 1'b0;
         end else if (w_capture) begin
            r_seen      <= w_seen_nxt;
            r_frame_bad <= r_frame_bad | w_dec[4];
         end
         if (w_done) begin
            r_pub     <= w_shadow_nxt;
            r_pub_bad <= r_frame_bad | w_dec[4];
         end
         r_pub_stb <= w_done;
      end
   end

   // Registered frame outputs, held between frames.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digit_o       <= '0;
         bad_seg_o     <= 1'b0;
         frame_valid_o <= 1'b0;
      end else begin
         frame_valid_o <= r_pub_stb;
         if (r_pub_stb) begin
            digit_o   <= r_pub;
            bad_seg_o <= r_pub_bad;
         end
      end
   end

`ifdef SEG7_RB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(32'd1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] r_wd;

   assign w_timeout = (r_wd == WD_LAST) && !w_done;

   // Watchdog counting cycles since the last completed frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wd    <= '0;
         stale_o <= 1'b0;
      end else begin
         if (w_done || w_timeout) begin
            r_wd <= '0;
         end else begin
            r_wd <= r_wd + WD_ONE;
         end
         if (w_timeout) begin
            stale_o <= 1'b1;
         end else if (r_pub_stb) begin
            stale_o <= 1'b0;
         end
      end
   end
`else
   // TIMEOUT_CYC has no effect in this build.
   assign w_timeout = 1'b0 & (TIMEOUT_CYC > 0);

   // Stale flag is never raised without the watchdog.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stale_o <= 1'b0;
      end else begin
         stale_o <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_seg7_readback.sv
// Scoreboard bench for seg7_readback: reference model predicts each published frame and its edge.
`timescale 1ns/1ps
module tb_seg7_readback;
   localparam int DIGITS = 4;
   localparam int STABLE = 4;
   localparam int TMO    = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_i;
   logic [3:0]  sel_n_i;
   logic [15:0] digit_o;
   logic        frame_valid_o;
   logic        bad_seg_o;
   logic        stale_o;

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   seg7_readback #(.DIGITS(DIGITS), .STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .seg_i(seg_i), .sel_n_i(sel_n_i),
      .digit_o(digit_o), .frame_valid_o(frame_valid_o),
      .bad_seg_o(bad_seg_o), .stale_o(stale_o));

   typedef struct { logic [15:0] d; logic bad; int edge_n; } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_fail = 0;
   int n_valid = 0;

   logic [6:0] pats [0:10];
   logic [6:0] m_seg;
   logic [3:0] m_sel;
   int         m_len;
   bit   [3:0] m_seen;
   logic [3:0] m_dig [0:3];
   bit         m_bad;
   int         m_wd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_seg = 7'h7F; m_sel = 4'hF; m_len = 0; m_seen = 4'h0; m_bad = 1'b0; m_wd = 0;
      for (int i = 0; i < DIGITS; i++) m_dig[i] = 4'h0;
   endtask

   // Model one clock edge with the inputs currently driven; the edge is edge_cnt+1.
   task automatic model_step();
      int zeros, idx;
      logic [3:0] code;
      bit bad, done;
      logic [15:0] w;
      if (seg_i == m_seg && sel_n_i == m_sel) m_len++; else m_len = 1;
      m_seg = seg_i; m_sel = sel_n_i;
      zeros = 0; idx = 0; done = 1'b0;
      for (int i = 0; i < DIGITS; i++) if (!sel_n_i[i]) begin zeros++; idx = i; end
      if (m_len == STABLE && zeros == 1) begin
         code = 4'hF; bad = 1'b1;
         for (int p = 0; p < 11; p++) if (seg_i == pats[p]) begin code = p[3:0]; bad = 1'b0; end
         m_dig[idx] = code; m_seen[idx] = 1'b1; m_bad = m_bad | bad;
         if (&m_seen) begin
            for (int i = 0; i < DIGITS; i++) w[4*i +: 4] = m_dig[i];
            sb.push_back('{w, m_bad, edge_cnt + 2});
            m_seen = 4'h0; m_bad = 1'b0; done = 1'b1;
         end
      end
      if (done) m_wd = 0; else m_wd++;
`ifdef SEG7_RB_TIMEOUT_EN
      if (m_wd == TMO) begin m_seen = 4'h0; m_bad = 1'b0; m_wd = 0; end
`endif
   endtask

   task automatic drive(input logic [6:0] s, input logic [3:0] n, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         seg_i = s; sel_n_i = n;
         model_step();
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      sb.delete();
      seg_i = 7'($urandom); sel_n_i = 4'($urandom);
      #2;
      check("reset_digit_o", 32'(digit_o), 32'h0);
      check("reset_frame_valid_o", 32'(frame_valid_o), 32'h0);
      check("reset_bad_seg_o", 32'(bad_seg_o), 32'h0);
      check("reset_stale_o", 32'(stale_o), 32'h0);
      repeat (3) @(negedge clk);
      model_reset();
      seg_i = 7'h7F; sel_n_i = 4'hF;
      rst = 1'b1;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (frame_valid_o) n_valid++;
         if (sb.size() > 0 && sb[0].edge_n <= edge_cnt) begin
            e = sb.pop_front();
            check("frame_valid_at_publish", 32'(frame_valid_o), 32'h1);
            check("publish_edge", 32'(edge_cnt), 32'(e.edge_n));
            check("digit_o", 32'(digit_o), 32'(e.d));
            check("bad_seg_o", 32'(bad_seg_o), 32'(e.bad));
            check("stale_o_on_valid", 32'(stale_o), 32'h0);
         end else if (frame_valid_o) begin
            check("spurious_frame_valid", 32'(frame_valid_o), 32'h0);
         end
      end
   endtask

   localparam logic [6:0] IDLE = 7'h7F;
   localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
   localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P7 = 7'b1111000, P8 = 7'b0000000;

   initial begin
      int v0;
      logic [3:0] hot;
      logic [6:0] s;
      logic [3:0] n;
      pats[0] = P0; pats[1] = P1; pats[2] = P2; pats[3] = P3; pats[4] = P4; pats[5] = P5;
      pats[6] = 7'b0000010; pats[7] = P7; pats[8] = P8; pats[9] = 7'b0010000; pats[10] = 7'b0111111;
      rst = 1'b0; seg_i = IDLE; sel_n_i = 4'hF;
      model_reset();
      fork monitor(); join_none
      @(negedge clk);
      do_reset();

      drive(IDLE, 4'hF, 20);
      check("idle_no_frame", 32'(n_valid), 32'd0);

      // Nominal frame
      v0 = n_valid;
      drive(P1, 4'b1110, 6); drive(P2, 4'b1101, 6); drive(P3, 4'b1011, 6); drive(P4, 4'b0111, 6);
      drive(IDLE, 4'hF, 3);
      check("nominal_one_pulse", 32'(n_valid), 32'(v0 + 1));
      check("nominal_digits", 32'(digit_o), 32'h4321);
      check("nominal_bad", 32'(bad_seg_o), 32'h0);

      // Glitch filter: 3 cycles short, exactly 4, then 100
      do_reset();
      v0 = n_valid;
      drive(P8, 4'b1110, 3); drive(P1, 4'b1101, 6); drive(P2, 4'b1011, 6); drive(P3, 4'b0111, 6);
      check("glitch_3_no_capture", 32'(n_valid), 32'(v0));
      drive(P8, 4'b1110, 4); drive(IDLE, 4'hF, 2);
      check("glitch_4_captured", 32'(n_valid), 32'(v0 + 1));
      check("glitch_4_digits", 32'(digit_o), 32'h3218);
      drive(P1, 4'b1101, 6); drive(P2, 4'b1011, 6); drive(P3, 4'b0111, 6);
      drive(P5, 4'b1110, 100); drive(IDLE, 4'hF, 2);
      check("hold_100_single_frame", 32'(n_valid), 32'(v0 + 2));
      check("hold_100_digits", 32'(digit_o), 32'h3215);

      // Illegal pattern and dash, then a clean frame
      do_reset();
      drive(P8, 4'b1110, 6); drive(P0, 4'b1101, 6); drive(7'b1010101, 4'b1011, 6); drive(7'b0111111, 4'b0111, 6);
      drive(IDLE, 4'hF, 2);
      check("illegal_digits", 32'(digit_o), 32'hAF08);
      check("illegal_bad", 32'(bad_seg_o), 32'h1);
      drive(P1, 4'b1110, 6); drive(P2, 4'b1101, 6); drive(P3, 4'b1011, 6); drive(P4, 4'b0111, 6);
      drive(IDLE, 4'hF, 2);
      check("clean_after_bad", 32'(bad_seg_o), 32'h0);

      // Blanking, multi-select, then overwrite of digit 1
      do_reset();
      v0 = n_valid;
      drive(P8, 4'hF, 10); drive(P8, 4'b1100, 10);
      drive(P2, 4'b1011, 6); drive(P5, 4'b1101, 6); drive(P0, 4'b1110, 6); drive(P7, 4'b1101, 6);
      check("blank_multi_no_capture", 32'(n_valid), 32'(v0));
      drive(P3, 4'b0111, 6); drive(IDLE, 4'hF, 2);
      check("overwrite_digits", 32'(digit_o), 32'h3270);

      // Watchdog
      do_reset();
      v0 = n_valid;
      drive(P0, 4'b1110, 6); drive(P1, 4'b1101, 6); drive(IDLE, 4'hF, 64);
`ifdef SEG7_RB_TIMEOUT_EN
      check("stale_after_timeout", 32'(stale_o), 32'h1);
      drive(P2, 4'b1011, 6); drive(P3, 4'b0111, 6);
      check("partial_frame_dropped", 32'(n_valid), 32'(v0));
      drive(P0, 4'b1110, 6); drive(P1, 4'b1101, 6); drive(IDLE, 4'hF, 2);
      check("frame_after_timeout", 32'(n_valid), 32'(v0 + 1));
      check("stale_cleared", 32'(stale_o), 32'h0);
      check("timeout_frame_digits", 32'(digit_o), 32'h3210);
`else
      check("stale_tied_low", 32'(stale_o), 32'h0);
`endif

      // Randomised traffic against the model
      do_reset();
      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 9) < 2) s = 7'($urandom);
         else s = pats[$urandom_range(0, 10)];
         if ($urandom_range(0, 9) < 8) begin
            hot = 4'b0001 << $urandom_range(0, 3);
            n = ~hot;
         end else begin
            n = 4'($urandom);
         end
         drive(s, n, $urandom_range(1, 7));
      end
      drive(IDLE, 4'hF, 4);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
